// File: rtl/counter_seq_pkg.sv
// rtl/counter_seq_pkg.sv - shared state type and default widths for counter_sequencer
package counter_seq_pkg;

   localparam int N_DEFAULT  = 32;
   localparam int PW_DEFAULT = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      PAUSE,
      DONE
   } state_t;

endpackage

// File: rtl/down_counter.sv
// rtl/down_counter.sv - N-bit loadable down counter with enable
module down_counter #(
   parameter int N = 32
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [N-1:0] load_value,
   input  logic         enable,
   output logic [N-1:0] value
);

   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

   // load takes precedence over decrement; the sequencer never lets it wrap below zero
   always_ff @(posedge clock) begin
      if (reset) begin
         value <= '0;
      end else if (load) begin
         value <= load_value;
      end else if (enable) begin
         value <= value - ONE;
      end
   end

endmodule

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - programmable timer sequencer (optional prescaler: COUNTER_SEQ_PRESCALE_EN)
module counter_sequencer
   import counter_seq_pkg::*;
#(
   parameter int N  = N_DEFAULT,
   parameter int PW = PW_DEFAULT
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic          pause,
   input  logic          resume,
   input  logic          oneshot,
   input  logic [N-1:0]  period,
`ifdef COUNTER_SEQ_PRESCALE_EN
   input  logic [PW-1:0] presc,
`endif
   output logic [N-1:0]  count,
   output logic          tick,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam logic [N-1:0]  ONE_N  = {{(N-1){1'b0}}, 1'b1};
   localparam logic [PW-1:0] ONE_PW = {{(PW-1){1'b0}}, 1'b1};

   state_t        state, next_state;
   logic [N-1:0]  per_q;
   logic          one_q;
   logic [PW-1:0] pre_q, pre_next;
   logic [PW-1:0] presc_value;
   logic          step;
   logic          latch;
   logic          tick_next, err_next;
   logic          ctr_load, ctr_enable;
   logic [N-1:0]  ctr_value;

   // without the prescaler a divisor of zero makes every RUN clock a step
`ifdef COUNTER_SEQ_PRESCALE_EN
   assign presc_value = presc;
`else
   assign presc_value = '0;
`endif

   down_counter #(.N(N)) u_counter (
      .clock      (clock),
      .reset      (reset),
      .load       (ctr_load),
      .load_value (ctr_value),
      .enable     (ctr_enable),
      .value      (count)
   );

   assign busy = (state == LOAD) || (state == RUN) || (state == PAUSE);
   assign done = (state == DONE);

   // state, latched period/mode, prescaler and registered pulses
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         per_q <= '0;
         one_q <= 1'b0;
         pre_q <= '0;
         tick  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= next_state;
         pre_q <= pre_next;
         tick  <= tick_next;
         err   <= err_next;
         if (latch) begin
            per_q <= period;
            one_q <= oneshot;
         end
      end
   end

   // next state and counter control; abort beats pause beats terminal step beats start
   always_comb begin
      next_state = state;
      pre_next   = pre_q;
      step       = (pre_q == presc_value);
      latch      = 1'b0;
      tick_next  = 1'b0;
      err_next   = 1'b0;
      ctr_load   = 1'b0;
      ctr_enable = 1'b0;
      ctr_value  = '0;
      if (abort) begin
         next_state = IDLE;
         ctr_load   = 1'b1;
         pre_next   = '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  if (period == '0) begin
                     err_next = 1'b1;
                  end else begin
                     latch      = 1'b1;
                     next_state = LOAD;
                  end
               end
            end
            LOAD: begin
               ctr_load   = 1'b1;
               ctr_value  = per_q - ONE_N;
               pre_next   = '0;
               next_state = RUN;
            end
            RUN: begin
               if (pause) begin
                  next_state = PAUSE;
               end else begin
                  pre_next = step ? '0 : pre_q + ONE_PW;
                  if (step) begin
                     if (count == '0) begin
                        tick_next = 1'b1;
                        if (one_q) begin
                           next_state = DONE;
                        end else begin
                           ctr_load  = 1'b1;
                           ctr_value = per_q - ONE_N;
                        end
                     end else begin
                        ctr_enable = 1'b1;
                     end
                  end
               end
            end
            PAUSE: begin
               if (resume) begin
                  next_state = RUN;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Control block that owns an N-bit loadable counter and sequences it as a programmable timer: loads a reference period, counts it down, and signals each terminal count with a tick pulse. Supports one-shot and periodic modes, pause/resume and abort. Sits between the lab top-level (buttons/switches, or a CPU-style register interface) and any logic that needs timed events, such as display refresh or LED blink.

## Interface
- N, 32, counter and period width
- PW, 8, prescaler width (used only with COUNTER_SEQ_PRESCALE_EN)
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle command: latch period/oneshot and begin
- abort  in  1  one-cycle command: return to IDLE from any state
- pause  in  1  one-cycle command: freeze count while running
- resume  in  1  one-cycle command: continue from PAUSE
- oneshot  in  1  1 = stop after first terminal count, 0 = periodic
- period  in  N  reference period P in counter steps; sampled on accepted start
- presc  in  PW  prescale divisor minus one (port exists only with macro)
- count  out  N  current counter value
- tick  out  1  one-cycle pulse per terminal count
- busy  out  1  high in LOAD, RUN, PAUSE
- done  out  1  level, high in DONE
- err  out  1  one-cycle pulse on rejected start (P == 0)

## Operation
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- Reset: state IDLE; count 0, tick 0, busy 0, done 0, err 0; latched period/mode cleared.
- IDLE/DONE + start, P != 0: latch P and oneshot, go to LOAD. With P == 0: pulse err, stay in current state.
- LOAD: assert counter load with P-1, go to RUN.
- RUN: on each step (every cycle, or per prescaler), count decrements. A step with count == 0 is terminal: tick pulses. Periodic mode reloads P-1 and stays in RUN. Oneshot mode goes to DONE with count held at 0.
- RUN + pause: go to PAUSE; count frozen, and that cycle's step is suppressed.
- PAUSE + resume: go to RUN. Resume outside PAUSE is ignored. Pause outside RUN is ignored.
- abort in any state: go to IDLE, count 0, prescaler cleared. No tick.
- Command priority in the same cycle: reset > abort > pause > terminal step > start. start while busy is ignored, with no err.
- DONE: done held until start (re-arm) or abort.
- Counter arithmetic is unsigned modulo 2^N. Decrement never wraps below 0, because terminal reload/stop happens first.

## Timing
- start sampled in cycle t: busy = 1 in t+1 (LOAD), count = P-1 in t+2 (RUN).
- tick is registered: high in the cycle after the terminal step, coinciding with the reloaded count (periodic) or done = 1 (oneshot).
- Tick period is exactly P steps. P = 1 gives tick every step.
- abort in cycle t: state IDLE, busy 0, count 0 in t+1.
- err is high in cycle t+1 for a rejected start in cycle t.

## Configuration
- COUNTER_SEQ_PRESCALE_EN defined: presc port present. An internal PW-bit prescaler produces one step every presc+1 clocks in RUN. The prescaler is cleared on LOAD and abort, and held in PAUSE.
- Not defined: no presc port, step every RUN clock.

## Structure
- Package counter_seq_pkg: typedef enum state_t {IDLE, LOAD, RUN, PAUSE, DONE}; default widths N and PW as localparams.
- Sub-module down_counter (N-bit; inputs load, load_value, enable; output value) instantiated once. The FSM and prescaler live in counter_sequencer.

## Test plan
- Reset mid-RUN (P=5) -> next cycle count 0, busy 0, done 0, tick 0.
- Periodic P=3, start at cycle 0 -> count 2,1,0 from cycle 2. tick at cycles 5, 8, 11. busy stays 1.
- Oneshot P=4 -> single tick at cycle 6. done = 1 from cycle 6, count 0. A later start with P=2 re-arms: done = 0 next cycle.
- start with P=0 in IDLE -> err pulse next cycle, state IDLE, busy 0.
- Periodic P=4, pause when count=2, hold 5 cycles, then resume -> count stays 2 while paused. The next tick lands 5+1 cycles later than it would without the pause. abort issued together with pause -> IDLE.
- With COUNTER_SEQ_PRESCALE_EN, presc=2, P=2 -> count changes every 3 clocks, tick every 6 clocks.
